// File: rtl/iterative_mult_unit_if.sv
// Execute-stage bundle between one issue lane and its iterative multiplier.
// The lane side is the master; the multiplier is the slave.
interface iterative_mult_unit_if #(
  parameter int WIDTH = 32
);

  logic                 mult_E;
  logic                 signed_E;
  logic [WIDTH-1:0]     srcA_E;
  logic [WIDTH-1:0]     srcB_E;
  logic                 stall_E;
  logic                 flush_E;
  logic                 multStall_E;
  logic                 busy;
  logic [2*WIDTH-1:0]   product_E;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output mult_E, signed_E, srcA_E, srcB_E, stall_E, flush_E,
    input  multStall_E, busy, product_E, hi, lo
  );

  modport slave (
    input  mult_E, signed_E, srcA_E, srcB_E, stall_E, flush_E,
    output multStall_E, busy, product_E, hi, lo
  );

endinterface

// File: rtl/iterative_mult_unit.sv
// Multi-cycle shift-add 32x32->64 multiplier for one issue lane's execute stage.
// Holds the lane in E while computing and commits the product to HI/LO when the mult leaves E.
module iterative_mult_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  iterative_mult_unit_if.slave mif
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [PW-1:0]       mcand_r;
  logic [WIDTH-1:0]    mplier_r;
  logic [PW-1:0]       acc_r;
  logic [PW-1:0]       acc_sum_s;
  logic                neg_r;
  logic [CNT_W-1:0]    count_r;
  logic [PW-1:0]       product_r;
  logic [WIDTH-1:0]    hi_r;
  logic [WIDTH-1:0]    lo_r;
  logic                last_step_s;
  logic                start_s;
  logic                commit_s;
  logic                mult_stall_s;
  logic                busy_s;

  // Absolute value of a two's-complement operand; the most negative value maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Full-width conditional two's-complement negate of the accumulated product.
  function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] v, input logic neg);
    if (neg) begin
      return ~v + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign last_step_s = (count_r == CNT_W'(N - 1));
  assign start_s     = (state_r == ST_IDLE) && mif.mult_E && !mif.flush_E;
  assign commit_s    = (state_r == ST_DONE) && !mif.stall_E && !mif.flush_E;

  // Partial-product step: mcand_r is pre-shifted, so each set multiplier bit adds a shifted copy.
  always_comb begin
    acc_sum_s = acc_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_r[i]) begin
        acc_sum_s = acc_sum_s + (mcand_r << i);
      end else begin
        acc_sum_s = acc_sum_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; flush wins over both start and commit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mif.flush_E) begin
          state_next_s = ST_IDLE;
        end else if (mif.mult_E) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mif.flush_E) begin
          state_next_s = ST_IDLE;
        end else if (last_step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (mif.flush_E) begin
          state_next_s = ST_IDLE;
        end else if (mif.stall_E) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: the stall request must never see stall_E/flush_E or the hazard unit loops.
  always_comb begin
    mult_stall_s = 1'b0;
    busy_s       = 1'b0;
    if (!reset_n) begin
      mult_stall_s = 1'b0;
      busy_s       = 1'b0;
    end else begin
      mult_stall_s = ((state_r == ST_IDLE) && mif.mult_E) || (state_r == ST_BUSY);
      busy_s       = (state_r != ST_IDLE);
    end
  end

  // Datapath: operand capture, iterative accumulation, product finalisation and HI/LO commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r   <= {PW{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {PW{1'b0}};
      neg_r     <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      product_r <= {PW{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(mif.srcA_E, mif.signed_E)};
            mplier_r <= magnitude(mif.srcB_E, mif.signed_E);
            neg_r    <= mif.signed_E && (mif.srcA_E[WIDTH-1] ^ mif.srcB_E[WIDTH-1]);
            acc_r    <= {PW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          if (mif.flush_E) begin
            acc_r   <= {PW{1'b0}};
            count_r <= {CNT_W{1'b0}};
          end else begin
            acc_r    <= acc_sum_s;
            mcand_r  <= mcand_r << BITS_PER_CYCLE;
            mplier_r <= mplier_r >> BITS_PER_CYCLE;
            count_r  <= count_r + CNT_W'(1);
            if (last_step_s) begin
              product_r <= cond_negate(acc_sum_s, neg_r);
            end
          end
        end
        ST_DONE: begin
          if (commit_s) begin
            hi_r <= product_r[PW-1:WIDTH];
            lo_r <= product_r[WIDTH-1:0];
          end
        end
        default: begin
          acc_r <= {PW{1'b0}};
        end
      endcase
    end
  end

  assign mif.multStall_E = mult_stall_s;
  assign mif.busy        = busy_s;
  assign mif.product_E   = product_r;
  assign mif.hi          = hi_r;
  assign mif.lo          = lo_r;

endmodule
